dicke_demodulator: RTL and testbench

- Synchronous Dicke-switch demodulator that sits between the ADC sample stream and the UART packetizer.
- Uses the switching PWM (looped back from the switch clock divider) to sort ADC samples into hot (antenna) and cold (reference load) accumulators.
- Blanks settling samples after every switch transition.
- Emits one signed difference per integration window, with a valid/ready handshake toward the UART stage.

---
 rtl/dicke_demodulator_if.sv | 23 ++
 rtl/dicke_demodulator.sv | 125 ++++++++++++
 tb/tb_dicke_demodulator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dicke_demodulator_if.sv
// rtl/dicke_demodulator_if.sv - sample, phase and result signals of the Dicke demodulator
interface dicke_demodulator_if #(
  parameter int SAMPLE_W = 12,
  parameter int ACC_W    = 24
);
  logic                 switch_phase;
  logic                 sample_valid;
  logic [SAMPLE_W-1:0]  sample;
  logic signed [ACC_W:0] demod;
  logic                 demod_valid;
  logic                 demod_ready;
  logic                 overrun;

  modport master (
    output switch_phase, sample_valid, sample, demod_ready,
    input  demod, demod_valid, overrun
  );

  modport slave (
    input  switch_phase, sample_valid, sample, demod_ready,
    output demod, demod_valid, overrun
  );
endinterface

// File: rtl/dicke_demodulator.sv
// rtl/dicke_demodulator.sv - sorts ADC samples into hot/cold accumulators by switch phase
// and emits hot minus cold once per integration window.
module dicke_demodulator #(
  parameter int SAMPLE_W = 12,
  parameter int ACC_W    = 24,
  parameter int BLANK    = 4,
  parameter int PERIODS  = 16
) (
  input logic                clk,
  input logic                rst,
  dicke_demodulator_if.slave bus
);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] INTEGRATE = 1'b1;

  logic [1:0] rst_pipe;
  logic       rst_i;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_i = rst_pipe[1];

  logic sync0, ph, ph_d;
  logic edge_cyc, rise;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync0 <= 1'b0;
      ph    <= 1'b0;
      ph_d  <= 1'b0;
    end else begin
      sync0 <= bus.switch_phase;
      ph    <= sync0;
      ph_d  <= ph;
    end
  end

  assign edge_cyc = ph ^ ph_d;
  assign rise     = edge_cyc & ph;

  logic [0:0]           state;
  logic [7:0]           blank_cnt;
  logic [15:0]          period_cnt;
  logic [16:0]          period_next;
  logic [ACC_W-1:0]     acc_hot, acc_cold, acc_sel, acc_sat;
  logic [ACC_W:0]       sample_ext, sum;
  logic signed [ACC_W:0] diff;
  logic                 window_done, take;

  assign period_next = {1'b0, period_cnt} + 17'd1;
  assign window_done = (state == INTEGRATE) && rise && (period_next == 17'(PERIODS));
  assign take        = (state == INTEGRATE) && bus.sample_valid && !edge_cyc && (blank_cnt == 8'd0);

  assign sample_ext = {{(ACC_W + 1 - SAMPLE_W){1'b0}}, bus.sample};
  assign acc_sel    = ph ? acc_hot : acc_cold;
  assign sum        = {1'b0, acc_sel} + sample_ext;
  // Carry out of the accumulator width pins it at full scale.
  assign acc_sat    = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign diff       = $signed({1'b0, acc_hot}) - $signed({1'b0, acc_cold});

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      blank_cnt  <= 8'd0;
      period_cnt <= 16'd0;
      acc_hot    <= '0;
      acc_cold   <= '0;
    end else begin
      if (edge_cyc)
        blank_cnt <= 8'(BLANK);
      else if ((state == INTEGRATE) && bus.sample_valid && (blank_cnt != 8'd0))
        blank_cnt <= blank_cnt - 8'd1;

      if (window_done) begin
        acc_hot  <= '0;
        acc_cold <= '0;
      end else if (take) begin
        if (ph) acc_hot  <= acc_sat;
        else    acc_cold <= acc_sat;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state      <= INTEGRATE;
            period_cnt <= 16'd0;
          end
        end
        default: begin
          if (window_done)
            period_cnt <= 16'd0;
          else if (rise)
            period_cnt <= period_next[15:0];
        end
      endcase
    end
  end

  logic signed [ACC_W:0] demod_q;
  logic                  valid_q;
  logic                  overrun_q;

  // A new result always wins the register; it only flags overrun if the old one was never taken.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      demod_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (window_done) begin
      demod_q <= diff;
      valid_q <= 1'b1;
      if (valid_q && !bus.demod_ready)
        overrun_q <= 1'b1;
    end else if (valid_q && bus.demod_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.demod       = demod_q;
  assign bus.demod_valid = valid_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_dicke_demodulator.sv
// tb/tb_dicke_demodulator.sv - directed bench for dicke_demodulator across three parameter sets
module tb_dicke_demodulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        sp    [3];
  logic        sv    [3];
  logic [11:0] smp   [3];
  logic        rdy   [3];
  logic        rst_v [3];

  dicke_demodulator_if #(.SAMPLE_W(12), .ACC_W(24)) if_a ();
  dicke_demodulator_if #(.SAMPLE_W(12), .ACC_W(12)) if_b ();
  dicke_demodulator_if #(.SAMPLE_W(12), .ACC_W(24)) if_c ();

  assign if_a.switch_phase = sp[0];
  assign if_a.sample_valid = sv[0];
  assign if_a.sample       = smp[0];
  assign if_a.demod_ready  = rdy[0];
  assign if_b.switch_phase = sp[1];
  assign if_b.sample_valid = sv[1];
  assign if_b.sample       = smp[1];
  assign if_b.demod_ready  = rdy[1];
  assign if_c.switch_phase = sp[2];
  assign if_c.sample_valid = sv[2];
  assign if_c.sample       = smp[2];
  assign if_c.demod_ready  = rdy[2];

  dicke_demodulator #(.SAMPLE_W(12), .ACC_W(24), .BLANK(2), .PERIODS(1))
    u_a (.clk(clk), .rst(rst_v[0]), .bus(if_a.slave));
  dicke_demodulator #(.SAMPLE_W(12), .ACC_W(12), .BLANK(0), .PERIODS(1))
    u_b (.clk(clk), .rst(rst_v[1]), .bus(if_b.slave));
  dicke_demodulator #(.SAMPLE_W(12), .ACC_W(24), .BLANK(2), .PERIODS(4))
    u_c (.clk(clk), .rst(rst_v[2]), .bus(if_c.slave));

  function automatic logic [31:0] dem(input int k);
    case (k)
      0:       return {{7{if_a.demod[24]}}, if_a.demod};
      1:       return {{19{if_b.demod[12]}}, if_b.demod};
      default: return {{7{if_c.demod[24]}}, if_c.demod};
    endcase
  endfunction

  function automatic logic [31:0] vld(input int k);
    case (k)
      0:       return {31'd0, if_a.demod_valid};
      1:       return {31'd0, if_b.demod_valid};
      default: return {31'd0, if_c.demod_valid};
    endcase
  endfunction

  function automatic logic [31:0] ovr(input int k);
    case (k)
      0:       return {31'd0, if_a.overrun};
      1:       return {31'd0, if_b.overrun};
      default: return {31'd0, if_c.overrun};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, $signed(obs), obs, $signed(expv), expv);
    end
  endtask

  task automatic send(input int k, input logic [11:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sv[k] = 1'b1; smp[k] = val;
      @(negedge clk); sv[k] = 1'b0;
    end
  endtask

  // Changes the phase and returns in the cycle right after the recognised edge cycle;
  // optional sample and ready pulse land exactly on that edge cycle.
  task automatic edge_to(input int k, input logic v, input logic smp_en,
                         input logic [11:0] val, input logic rdy_pulse);
    @(negedge clk); sp[k] = v;
    @(negedge clk);
    @(negedge clk);
    if (smp_en) begin sv[k] = 1'b1; smp[k] = val; end
    if (rdy_pulse) rdy[k] = 1'b1;
    @(negedge clk);
    sv[k] = 1'b0;
    if (rdy_pulse) rdy[k] = 1'b0;
  endtask

  task automatic full_cycle(input int k, input logic [11:0] hot, input logic [11:0] cold);
    send(k, hot, 6);
    edge_to(k, 1'b0, 1'b0, 12'd0, 1'b0);
    send(k, cold, 6);
    edge_to(k, 1'b1, 1'b0, 12'd0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; sp[k] = 1'b0; sv[k] = 1'b0; smp[k] = 12'd0;
    end
    rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_demod", dem(0), 32'd0);
    check("reset_valid", vld(0), 32'd0);
    check("reset_overrun", ovr(0), 32'd0);
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
    repeat (6) @(negedge clk);

    // Basic difference, ready held high.
    edge_to(0, 1'b1, 1'b0, 12'd0, 1'b0);
    full_cycle(0, 12'd100, 12'd40);
    check("basic_valid", vld(0), 32'd1);
    check("basic_demod", dem(0), 32'd240);
    check("basic_overrun", ovr(0), 32'd0);
    @(negedge clk);
    check("basic_valid_drop", vld(0), 32'd0);

    // Accept and load on the same edge.
    rdy[0] = 1'b0;
    full_cycle(0, 12'd100, 12'd40);
    check("hold_valid", vld(0), 32'd1);
    check("hold_demod", dem(0), 32'd240);
    send(0, 12'd50, 6);
    edge_to(0, 1'b0, 1'b0, 12'd0, 1'b0);
    send(0, 12'd0, 6);
    edge_to(0, 1'b1, 1'b0, 12'd0, 1'b1);
    check("simul_valid", vld(0), 32'd1);
    check("simul_demod", dem(0), 32'd200);
    check("simul_overrun", ovr(0), 32'd0);
    @(negedge clk); rdy[0] = 1'b1;
    @(negedge clk); rdy[0] = 1'b0;
    check("drain_valid", vld(0), 32'd0);

    // Backpressure across two windows.
    full_cycle(0, 12'd100, 12'd40);
    check("bp_first_demod", dem(0), 32'd240);
    check("bp_first_overrun", ovr(0), 32'd0);
    full_cycle(0, 12'd100, 12'd25);
    check("bp_second_demod", dem(0), 32'd300);
    check("bp_second_valid", vld(0), 32'd1);
    check("bp_overrun_set", ovr(0), 32'd1);
    @(negedge clk); rdy[0] = 1'b1;
    @(negedge clk); rdy[0] = 1'b0;
    check("bp_accept_valid", vld(0), 32'd0);
    check("bp_overrun_sticky", ovr(0), 32'd1);

    // Edge-cycle sample is dropped (500 would land in the cold accumulator).
    edge_to(1, 1'b1, 1'b0, 12'd0, 1'b0);
    send(1, 12'd10, 5);
    edge_to(1, 1'b0, 1'b1, 12'd500, 1'b0);
    send(1, 12'd0, 3);
    edge_to(1, 1'b1, 1'b0, 12'd0, 1'b0);
    check("edge_discard_valid", vld(1), 32'd1);
    check("edge_discard_demod", dem(1), 32'd50);

    // Saturation at 12 bits, then a negative result.
    send(1, 12'd4095, 2);
    edge_to(1, 1'b0, 1'b0, 12'd0, 1'b0);
    send(1, 12'd4095, 1);
    send(1, 12'd0, 2);
    edge_to(1, 1'b1, 1'b0, 12'd0, 1'b0);
    check("sat_demod", dem(1), 32'd0);
    send(1, 12'd0, 2);
    edge_to(1, 1'b0, 1'b0, 12'd0, 1'b0);
    send(1, 12'd4095, 1);
    send(1, 12'd0, 2);
    edge_to(1, 1'b1, 1'b0, 12'd0, 1'b0);
    check("neg_demod", dem(1), 32'hFFFF_F001);
    check("neg_valid", vld(1), 32'd1);

    // Four-period window, then reset in the middle of the next one.
    edge_to(2, 1'b1, 1'b0, 12'd0, 1'b0);
    for (int c = 0; c < 4; c++) full_cycle(2, 12'd100, 12'd40);
    check("p4_demod", dem(2), 32'd960);
    check("p4_valid", vld(2), 32'd1);
    for (int c = 0; c < 2; c++) full_cycle(2, 12'd100, 12'd40);
    send(2, 12'd100, 3);
    @(negedge clk); rst_v[2] = 1'b1; sp[2] = 1'b0;
    #1;
    check("midrst_demod", dem(2), 32'd0);
    check("midrst_valid", vld(2), 32'd0);
    check("midrst_overrun", ovr(2), 32'd0);
    repeat (3) @(negedge clk);
    rst_v[2] = 1'b0;
    repeat (6) @(negedge clk);
    send(2, 12'd1000, 4);
    edge_to(2, 1'b1, 1'b0, 12'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      full_cycle(2, 12'd100, 12'd40);
      if (c < 3) check("postrst_early_valid", vld(2), 32'd0);
    end
    check("postrst_demod", dem(2), 32'd960);
    check("postrst_valid", vld(2), 32'd1);
    check("postrst_overrun", ovr(2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
